uart_frame: RTL and testbench
=============================

UART_FRAME -- requirements
Module: uart_frame

Interface
REQ-001 Parameter BAUD_DIV, default 104; clk cycles per bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 clk  in  1  reference clock; the block SHALL use one clock only.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 Rx  in  1  serial input; asynchronous to clk.
REQ-008 Tx  out  1  serial output; idle high.
REQ-009 I_DATA  in  DATA_BITS  word to transmit.
REQ-010 send_data  in  1  transmit request.
REQ-011 TiP  out  1  transmission in progress.
REQ-012 O_DATA  out  DATA_BITS  last received word.
REQ-013 NrD  out  1  new-data strobe, one cycle wide.
REQ-014 PErr  out  1  parity error of the last frame; qualified by NrD.
REQ-015 FErr  out  1  framing error of the last frame; qualified by NrD.

Function
REQ-016 Transmitter: a cycle with send_data=1 and TiP=0 SHALL latch I_DATA; TiP SHALL rise on the next cycle, with Tx driven low (start bit) on that same cycle.
REQ-017 Bit order: start(0), data LSB first, parity (if PARITY != 0), STOP_BITS stop bits(1); each bit lasts exactly BAUD_DIV cycles.
REQ-018 Parity: odd mode makes the count of ones over data+parity odd; even mode makes it even.
REQ-019 TiP SHALL fall in the cycle after the last stop-bit cycle; send_data held high then starts the next frame with no idle bit.
REQ-020 send_data while TiP=1 SHALL be ignored; I_DATA changes after acceptance SHALL NOT affect the frame in flight.
REQ-021 Receiver: Rx SHALL pass through a 2-flop synchroniser; all receiver logic uses the synchronised value.
REQ-022 RX FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE; an additional WAIT_HIGH state follows a framing error.
REQ-023 IDLE -> START on a synchronised high-to-low transition; START samples at BAUD_DIV/2 (integer division); if the sample is high, the receiver SHALL return to IDLE with no NrD (glitch rejection).
REQ-024 Every following bit SHALL be sampled BAUD_DIV cycles after the previous sample (mid-bit).
REQ-025 Only the first stop bit is checked; at its sample cycle, O_DATA, PErr and FErr SHALL update, and NrD SHALL pulse high for exactly one cycle.
REQ-026 FErr=1 when the stop sample is 0; the FSM then SHALL enter WAIT_HIGH and SHALL stay there until Rx is high (break handling), then go to IDLE.
REQ-027 PErr SHALL be 0 when PARITY=0.
REQ-028 With STOP_BITS=2, the receiver SHALL return to IDLE after the first stop sample, so it accepts both 1- and 2-stop senders.
REQ-029 Tx and Rx paths SHALL be fully independent; simultaneous operation, including loopback Tx->Rx, SHALL work.

Reset
REQ-030 While rst=1: Tx=1, TiP=0, NrD=0, PErr=0, FErr=0, O_DATA=0, both FSMs IDLE, counters 0.
REQ-031 rst asserted mid-frame SHALL abort both frames at the next clk edge; the first action after rst falls SHALL be a new send_data or a new start edge.

Structure
REQ-032 A shared package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the standard BAUD_DIV constants for a 12 MHz clk (B9600=1250, B115200=104, etc.).
REQ-033 One sub-module, uart_baud_gen, SHALL provide a restartable bit-period counter (inputs: restart, half_first; output: tick); it SHALL be instantiated once for TX and once for RX.

Verification
REQ-034 Defaults, I_DATA=0x55, send_data pulse -> Tx = 0,1,0,1,0,1,0,1,0,1 with 104 cycles per bit; TiP high for 1040 cycles.
REQ-035 PARITY=2, DATA_BITS=7, loopback of 0x41 -> NrD pulse, O_DATA=0x41, PErr=0, FErr=0; forced inverted parity bit -> PErr=1.
REQ-036 Rx low pulse of 30 cycles from idle -> no NrD; receiver back in IDLE.
REQ-037 Rx held low for 20 bit times -> one NrD with O_DATA=0, FErr=1; no further NrD until Rx returns high and a new start bit arrives.
REQ-038 STOP_BITS=2, send_data held high for 3 words -> back-to-back frames with 2 stop bits each; later I_DATA changes during a frame do not corrupt that frame.
REQ-039 rst pulse in the middle of the DATA phase on both paths -> Tx=1 and TiP=0 on the next cycle; no NrD; the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, 12 MHz baud divisors, FSM encodings
// and the parity helper used by both the transmit and receive paths.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // clk cycles per bit for a 12 MHz reference
    localparam int B9600   = 1250;
    localparam int B19200  = 625;
    localparam int B38400  = 313;
    localparam int B57600  = 208;
    localparam int B115200 = 104;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Data is zero-extended to 9 bits by the caller; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: tick marks the last cycle of each bit period,
// or the mid-bit sample point when the period was restarted with half_first.
module uart_baud_gen #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_half_first,
    output logic o_tick
);

    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= i_half_first ? HALF_M1 : FULL_M1;
        end else if (r_cnt == '0) begin
            r_cnt <= FULL_M1;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // Free-running between restarts; consumers ignore tick while idle.
    assign o_tick = (r_cnt == '0) && !i_restart;

endmodule

// File: rtl/uart_frame.sv
// Full-duplex UART framer: independent transmitter and receiver sharing one clock,
// each timed by its own uart_baud_gen.
module uart_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic [DATA_BITS-1:0] I_DATA,
    input  logic                 send_data,
    output logic                 TiP,
    output logic [DATA_BITS-1:0] O_DATA,
    output logic                 NrD,
    output logic                 PErr,
    output logic                 FErr,
    output logic [2:0]           o_rx_state,
    output logic                 o_tx_state
);

    localparam int         PAR_W   = (PARITY != PAR_NONE) ? 1 : 0;
    localparam int         FRAME_W = 1 + DATA_BITS + PAR_W + STOP_BITS;
    localparam logic [3:0] TX_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] RX_LAST = 4'(DATA_BITS - 1);

    // Handshake: send_data is a request; it is accepted in any cycle where TiP=0,
    // and TiP (the busy flag) stays high for the whole frame, ignoring requests.
    tx_state_t            r_tx_state, w_tx_next;
    logic [FRAME_W-1:0]   r_tx_shift, w_tx_frame;
    logic [3:0]           r_tx_bits;
    logic [8:0]           w_tx_ext;
    logic                 w_tx_accept, w_tx_tick;

    always_comb begin
        w_tx_ext                   = '0;
        w_tx_ext[DATA_BITS-1:0]    = I_DATA;
        w_tx_frame                 = '1;
        w_tx_frame[0]              = 1'b0;
        w_tx_frame[DATA_BITS:1]    = I_DATA;
        if (PARITY != PAR_NONE) begin
            w_tx_frame[DATA_BITS+1] = parity_bit(w_tx_ext, PARITY);
        end
    end

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_accept = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (send_data) begin
                    w_tx_accept = 1'b1;
                    w_tx_next   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (w_tx_tick && (r_tx_bits == '0)) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '1;
            r_tx_bits  <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_accept) begin
                r_tx_shift <= w_tx_frame;
                r_tx_bits  <= TX_LAST;
            end else if ((r_tx_state == TX_SEND) && w_tx_tick) begin
                r_tx_shift <= {1'b1, r_tx_shift[FRAME_W-1:1]};
                r_tx_bits  <= r_tx_bits - 4'd1;
            end
        end
    end

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
        .clk          (clk),
        .rst          (rst),
        .i_restart    (w_tx_accept),
        .i_half_first (1'b0),
        .o_tick       (w_tx_tick)
    );

    assign TiP        = (r_tx_state == TX_SEND);
    assign Tx         = TiP ? r_tx_shift[0] : 1'b1;
    assign o_tx_state = r_tx_state;

    rx_state_t            r_rx_state, w_rx_next;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [DATA_BITS-1:0] r_rx_shift, r_odata;
    logic [3:0]           r_rx_bits;
    logic [8:0]           w_rx_ext;
    logic                 r_rx_par, r_nrd, r_perr, r_ferr;
    logic                 w_rx_tick, w_rx_restart, w_rx_done, w_rx_fall;

    // Synchroniser resets low so a line already low after reset is not a start edge.
    assign w_rx_fall = r_rx_prev & ~r_rx_s2;

    always_comb begin
        w_rx_ext                = '0;
        w_rx_ext[DATA_BITS-1:0] = r_rx_shift;
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_restart = 1'b0;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_restart = 1'b1;
                    w_rx_next    = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_tick && (r_rx_bits == RX_LAST)) begin
                    w_rx_next = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rx_tick) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_done = 1'b1;
                    w_rx_next = r_rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx_s2) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b0;
            r_rx_s2    <= 1'b0;
            r_rx_prev  <= 1'b0;
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_bits  <= '0;
            r_rx_par   <= 1'b0;
            r_odata    <= '0;
            r_nrd      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_s1    <= Rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_nrd      <= w_rx_done;
            if (w_rx_restart) r_rx_bits <= '0;
            if ((r_rx_state == RX_DATA) && w_rx_tick) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bits  <= r_rx_bits + 4'd1;
            end
            if ((r_rx_state == RX_PARITY) && w_rx_tick) r_rx_par <= r_rx_s2;
            if (w_rx_done) begin
                r_odata <= r_rx_shift;
                r_ferr  <= ~r_rx_s2;
                r_perr  <= (PARITY != PAR_NONE) && (parity_bit(w_rx_ext, PARITY) != r_rx_par);
            end
        end
    end

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
        .clk          (clk),
        .rst          (rst),
        .i_restart    (w_rx_restart),
        .i_half_first (1'b1),
        .o_tick       (w_rx_tick)
    );

    assign O_DATA     = r_odata;
    assign NrD        = r_nrd;
    assign PErr       = r_perr;
    assign FErr       = r_ferr;
    assign o_rx_state = r_rx_state;

endmodule

// File: tb/tb_uart_frame.sv
// Directed bench for uart_frame: a default-parameter instance (A) and a
// 7-bit even-parity, 2-stop, fast-baud instance (B) looped back on itself.
module tb_uart_frame;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    logic clk, rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       a_rx_drv, a_loop, a_rx, a_tx, a_send, a_tip, a_nrd, a_perr, a_ferr, a_tx_state;
    logic [7:0] a_idata, a_odata;
    logic [2:0] a_rx_state;

    logic       b_flip, b_rx, b_tx, b_send, b_tip, b_nrd, b_perr, b_ferr, b_tx_state;
    logic [6:0] b_idata, b_odata;
    logic [2:0] b_rx_state;
    logic [6:0] exp_q[$];

    assign a_rx = a_loop ? a_tx : a_rx_drv;
    assign b_rx = b_tx ^ b_flip;

    uart_frame u_a (
        .clk(clk), .rst(rst), .Rx(a_rx), .Tx(a_tx), .I_DATA(a_idata), .send_data(a_send),
        .TiP(a_tip), .O_DATA(a_odata), .NrD(a_nrd), .PErr(a_perr), .FErr(a_ferr),
        .o_rx_state(a_rx_state), .o_tx_state(a_tx_state)
    );

    uart_frame #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .Rx(b_rx), .Tx(b_tx), .I_DATA(b_idata), .send_data(b_send),
        .TiP(b_tip), .O_DATA(b_odata), .NrD(b_nrd), .PErr(b_perr), .FErr(b_ferr),
        .o_rx_state(b_rx_state), .o_tx_state(b_tx_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send_a(input logic [7:0] d);
        a_idata = d;
        a_send  = 1'b1;
        @(negedge clk);
        a_send  = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] d);
        b_idata = d;
        b_send  = 1'b1;
        @(negedge clk);
        b_send  = 1'b0;
    endtask

    task automatic wait_nrd(input bit sel, input int max_cyc, output bit found,
                            output logic [8:0] data, output logic perr, output logic ferr);
        found = 1'b0;
        data  = '0;
        perr  = 1'b0;
        ferr  = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if (sel ? b_nrd : a_nrd) begin
                found = 1'b1;
                data  = sel ? {2'b00, b_odata} : {1'b0, a_odata};
                perr  = sel ? b_perr : a_perr;
                ferr  = sel ? b_ferr : a_ferr;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_send = 1'b0; a_idata = '0; a_loop = 1'b0; a_rx_drv = 1'b1;
        b_send = 1'b0; b_idata = '0; b_flip = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_tx, a_tip, a_nrd, a_perr, a_ferr} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_a_flags: got %b expected 10000", {a_tx, a_tip, a_nrd, a_perr, a_ferr});
        end
        n_tests++;
        if (a_odata !== 8'h00) begin
            n_fail++; $display("FAIL reset_a_odata: got %h expected 00", a_odata);
        end
        n_tests++;
        if ({a_rx_state, a_tx_state} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_a_states: got %b expected 0000", {a_rx_state, a_tx_state});
        end
        n_tests++;
        if ({b_tx, b_tip, b_nrd, b_perr, b_ferr, b_odata} !== {5'b10000, 7'h00}) begin
            n_fail++; $display("FAIL reset_b_outputs: got %b %h expected 10000 00", {b_tx, b_tip, b_nrd, b_perr, b_ferr}, b_odata);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_tx_pattern();
        logic [9:0] exp_frame;
        exp_frame = 10'b1_0101_0101_0;
        send_a(8'h55);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 104; c++) begin
                n_tests++;
                if ({a_tip, a_tx} !== {1'b1, exp_frame[b]}) begin
                    n_fail++; $display("FAIL tx_55 bit %0d cyc %0d: got tip/tx %b expected %b", b, c, {a_tip, a_tx}, {1'b1, exp_frame[b]});
                end
                @(negedge clk);
            end
        end
        n_tests++;
        if ({a_tip, a_tx} !== 2'b01) begin
            n_fail++; $display("FAIL tx_55_end: got tip/tx %b expected 01", {a_tip, a_tx});
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        int nrd_seen;
        nrd_seen = 0;
        a_rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (a_rx_state !== ST_START) begin
            n_fail++; $display("FAIL glitch_start: got state %0d expected %0d", a_rx_state, ST_START);
        end
        repeat (20) @(negedge clk);
        a_rx_drv = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (a_nrd) nrd_seen++;
        end
        n_tests++;
        if (nrd_seen !== 0) begin
            n_fail++; $display("FAIL glitch_nrd: got %0d pulses expected 0", nrd_seen);
        end
        n_tests++;
        if (a_rx_state !== ST_IDLE) begin
            n_fail++; $display("FAIL glitch_idle: got state %0d expected %0d", a_rx_state, ST_IDLE);
        end
    endtask

    task automatic test_break();
        int         nrd_seen;
        logic [7:0] got_data;
        logic       got_ferr, got_perr, perr, ferr;
        logic [8:0] data;
        bit         found;
        nrd_seen = 0; got_data = 8'hFF; got_ferr = 1'b0; got_perr = 1'b1;
        a_rx_drv = 1'b0;
        for (int i = 0; i < 2080; i++) begin
            @(negedge clk);
            if (a_nrd) begin
                nrd_seen++;
                got_data = a_odata; got_ferr = a_ferr; got_perr = a_perr;
            end
        end
        n_tests++;
        if (nrd_seen !== 1) begin
            n_fail++; $display("FAIL break_nrd_count: got %0d expected 1", nrd_seen);
        end
        n_tests++;
        if ({got_data, got_ferr, got_perr} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL break_frame: got data %h ferr %b perr %b expected 00 1 0", got_data, got_ferr, got_perr);
        end
        n_tests++;
        if (a_rx_state !== ST_WAIT_HIGH) begin
            n_fail++; $display("FAIL break_wait_high: got state %0d expected %0d", a_rx_state, ST_WAIT_HIGH);
        end
        nrd_seen = 0;
        a_rx_drv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_nrd) nrd_seen++;
        end
        n_tests++;
        if ({nrd_seen, a_rx_state} !== {32'd0, ST_IDLE}) begin
            n_fail++; $display("FAIL break_release: got nrd %0d state %0d expected 0 %0d", nrd_seen, a_rx_state, ST_IDLE);
        end
        a_loop = 1'b1;
        send_a(8'hA5);
        wait_nrd(1'b0, 1500, found, data, perr, ferr);
        n_tests++;
        if ({found, data, perr, ferr} !== {1'b1, 9'h0A5, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL break_next_frame: got found %b data %h perr %b ferr %b expected 1 0a5 0 0", found, data, perr, ferr);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int         nrd_seen;
        logic [8:0] data;
        logic       perr, ferr;
        bit         found;
        nrd_seen = 0;
        send_a(8'h3C);
        repeat (416) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({a_tx, a_tip, a_rx_state} !== {1'b1, 1'b0, ST_IDLE}) begin
            n_fail++; $display("FAIL midrst_abort: got tx %b tip %b state %0d expected 1 0 0", a_tx, a_tip, a_rx_state);
        end
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (a_nrd) nrd_seen++;
        end
        n_tests++;
        if (nrd_seen !== 0) begin
            n_fail++; $display("FAIL midrst_nrd: got %0d pulses expected 0", nrd_seen);
        end
        send_a(8'hC3);
        wait_nrd(1'b0, 1500, found, data, perr, ferr);
        n_tests++;
        if ({found, data, perr, ferr} !== {1'b1, 9'h0C3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL midrst_next_frame: got found %b data %h perr %b ferr %b expected 1 0c3 0 0", found, data, perr, ferr);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_parity_loopback();
        logic [8:0] data;
        logic       perr, ferr;
        bit         found;
        send_b(7'h41);
        wait_nrd(1'b1, 300, found, data, perr, ferr);
        n_tests++;
        if ({found, data, perr, ferr} !== {1'b1, 9'h041, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL parity_ok: got found %b data %h perr %b ferr %b expected 1 041 0 0", found, data, perr, ferr);
        end
        @(negedge clk);
        n_tests++;
        if (b_nrd !== 1'b0) begin
            n_fail++; $display("FAIL parity_nrd_width: got %b expected 0", b_nrd);
        end
        repeat (40) @(negedge clk);
        send_b(7'h41);
        repeat (128) @(negedge clk);
        b_flip = 1'b1;
        repeat (16) @(negedge clk);
        b_flip = 1'b0;
        wait_nrd(1'b1, 200, found, data, perr, ferr);
        n_tests++;
        if ({found, data, perr, ferr} !== {1'b1, 9'h041, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL parity_flip: got found %b data %h perr %b ferr %b expected 1 041 1 0", found, data, perr, ferr);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        logic       exp_tip;
        int         p, bit_idx;
        exp_q = {};
        b_idata = 7'h2A;
        b_send  = 1'b1;
        exp_q.push_back(7'h2A);
        for (int i = 1; i <= 560; i++) begin
            @(negedge clk);
            exp_tip = (i <= 531) && ((i % 177) != 0);
            n_tests++;
            if (b_tip !== exp_tip) begin
                n_fail++; $display("FAIL b2b_tip cyc %0d: got %b expected %b", i, b_tip, exp_tip);
            end
            if (exp_tip) begin
                p = i % 177;
                bit_idx = (p - 1) / 16;
                if (bit_idx == 0 || bit_idx >= 9) begin
                    n_tests++;
                    if (b_tx !== (bit_idx != 0)) begin
                        n_fail++; $display("FAIL b2b_tx cyc %0d bit %0d: got %b expected %b", i, bit_idx, b_tx, (bit_idx != 0));
                    end
                end
            end
            if (b_nrd) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_word: got %h expected none", b_odata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({b_odata, b_perr, b_ferr} !== {exp, 2'b00}) begin
                        n_fail++; $display("FAIL b2b_word: got %h perr %b ferr %b expected %h 0 0", b_odata, b_perr, b_ferr, exp);
                    end
                end
            end
            if (i == 50) begin
                b_idata = 7'h15;
                exp_q.push_back(7'h15);
            end
            if (i == 227) begin
                b_idata = 7'h63;
                exp_q.push_back(7'h63);
            end
            if (i == 404) b_send = 1'b0;
        end
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_missing: got %0d words outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_tx_pattern();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_parity_loopback();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
